// File: rtl/sm_regdump_pkg.sv
// Shared types and constants for the register-dump UART streamer.
package sm_regdump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_CAPT = 3'd2,
    ST_HDR  = 3'd3,
    ST_DATA = 3'd4,
    ST_NEXT = 3'd5
  } state_t;

  localparam int DEF_CLK_DIV = 434;
  localparam int REC_BYTES   = 5;

  function automatic logic [7:0] hdr_byte(input logic [4:0] idx);
    return {3'b000, idx};
  endfunction

  // Data bytes go out MSB first: sel 0 is word[31:24].
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      2'd3:    b = word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sm_regdump_uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte handshake.
module sm_uart_tx
  import sm_regdump_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int            CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0] PER_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] per_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic          active;
  logic          last_tick;

  // Ready also in the final cycle of the stop bit so frames run back-to-back.
  assign last_tick = active && (per_cnt == PER_MAX) && (bit_cnt == 4'd9);
  assign ready     = !active || last_tick;
  assign tx        = shreg[0];

  // Frame sequencing; the line is the LSB of the shift register, idle all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= 10'h3FF;
      per_cnt <= '0;
      bit_cnt <= 4'd0;
      active  <= 1'b0;
    end else if (valid && ready) begin
      shreg   <= {1'b1, data, 1'b0};
      per_cnt <= '0;
      bit_cnt <= 4'd0;
      active  <= 1'b1;
    end else if (active) begin
      if (per_cnt == PER_MAX) begin
        per_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {1'b1, shreg[9:1]};
        end
      end else begin
        per_cnt <= per_cnt + CW'(1);
      end
    end else begin
      shreg <= 10'h3FF;
    end
  end

endmodule

// File: rtl/sm_regdump.sv
// Walks the CPU debug register port and streams index + 32-bit value per register over UART.
module sm_regdump
  import sm_regdump_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int REG_FIRST = 0,
  parameter int REG_LAST  = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST_IDX = 5'(REG_FIRST);
  localparam logic [4:0] LAST_IDX  = 5'(REG_LAST);
  localparam logic [1:0] LAST_BYTE = 2'(REC_BYTES - 2);

  state_t      state;
  logic [4:0]  index;
  logic [31:0] word;
  logic [1:0]  byte_cnt;
  logic        sent_all;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_byte;

  assign regAddr = index;

  // Byte offered to the transmitter in the current state.
  always_comb begin
    tx_valid = 1'b0;
    tx_byte  = hdr_byte(index);
    case (state)
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_byte  = hdr_byte(index);
      end
      ST_DATA: begin
        tx_valid = !sent_all;
        tx_byte  = word_byte(word, byte_cnt);
      end
      default: begin
        tx_valid = 1'b0;
        tx_byte  = hdr_byte(index);
      end
    endcase
  end

  // Dump sequencer; done/busy change as the last stop bit ends so NEXT is the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      index    <= 5'd0;
      word     <= 32'd0;
      byte_cnt <= 2'd0;
      sent_all <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            index <= FIRST_IDX;
            busy  <= 1'b1;
            state <= ST_ADDR;
          end
        end
        ST_ADDR: state <= ST_CAPT;
        ST_CAPT: begin
          word  <= regData;
          state <= ST_HDR;
        end
        ST_HDR: begin
          if (tx_ready) begin
            byte_cnt <= 2'd0;
            sent_all <= 1'b0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tx_ready) begin
            if (sent_all) begin
              state <= ST_NEXT;
              if (index == LAST_IDX) begin
                done <= 1'b1;
                busy <= 1'b0;
              end
            end else if (byte_cnt == LAST_BYTE) begin
              sent_all <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        ST_NEXT: begin
          if (index == LAST_IDX) begin
            index <= 5'd0;
            state <= ST_IDLE;
          end else begin
            index <= index + 5'd1;
            state <= ST_ADDR;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sm_uart_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (tx_byte),
    .valid (tx_valid),
    .ready (tx_ready),
    .tx    (tx)
  );

endmodule

// File: tb/tb_sm_regdump.sv
// Bench for sm_regdump: a full-range and a single-register instance against a schedule model.
module tb_sm_regdump;

  localparam int CD    = 4;
  localparam int FRAME = 10 * CD;
  localparam int REC   = 4 + 5 * FRAME;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [4:0]  ra0, ra1;
  logic [31:0] rd0, rd1;
  logic        tx0, tx1, busy0, busy1, done0, done1;
  logic [31:0] regs [32];

  int checks = 0, failures = 0, cyc = 0;
  int nreg  [2] = '{32, 1};
  int first [2] = '{0, 5};
  bit act   [2] = '{1'b0, 1'b0};
  int t0    [2] = '{0, 0};
  logic [31:0] snap [2][32];
  logic [7:0]  rxq0 [$];
  logic [7:0]  rxq1 [$];
  int dec_pos [2] = '{-1, -1};
  logic [7:0] dec_sh [2];
  int dn0 = 0, dn1 = 0;

  assign rd0 = regs[ra0];
  assign rd1 = regs[ra1];

  always #5 clk = ~clk;

  sm_regdump #(.CLK_DIV(CD), .REG_FIRST(0), .REG_LAST(31)) u_full (
    .clk(clk), .rst_n(rst_n), .start(start0), .regAddr(ra0), .regData(rd0),
    .tx(tx0), .busy(busy0), .done(done0));

  sm_regdump #(.CLK_DIV(CD), .REG_FIRST(5), .REG_LAST(5)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start1), .regAddr(ra1), .regData(rd1),
    .tx(tx1), .busy(busy1), .done(done1));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rxb(input int d, input int i);
    if (d == 0) return (i < rxq0.size()) ? rxq0[i] : 8'hxx;
    else        return (i < rxq1.size()) ? rxq1[i] : 8'hxx;
  endfunction

  task automatic chk_rec(input string nm, input int d, input int base, input logic [39:0] exp);
    for (int i = 0; i < 5; i++) begin
      logic [39:0] e;
      e = exp >> (8 * (4 - i));
      chk($sformatf("%s_b%0d", nm, i), 32'(rxb(d, base + i)), 32'(e[7:0]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Schedule model: every output is a function of the cycle offset from the accepted start.
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      logic [31:0] e_tx, e_busy, e_done, e_ra;
      logic [7:0]  byt;
      logic        g_tx, g_busy, g_done, g_st;
      logic [4:0]  g_ra;
      int o, endo, k, w, b, bi;
      if (d == 0) begin g_tx = tx0; g_busy = busy0; g_done = done0; g_ra = ra0; g_st = start0; end
      else        begin g_tx = tx1; g_busy = busy1; g_done = done1; g_ra = ra1; g_st = start1; end
      if (!rst_n) act[d] = 1'b0;
      o = cyc - t0[d];
      endo = nreg[d] * REC;
      e_tx = 32'd1; e_busy = 32'd0; e_done = 32'd0; e_ra = 32'd0;
      if (act[d] && o <= endo) begin
        if (o >= 2 && (o - 2) % REC == 0 && (o - 2) / REC < nreg[d])
          snap[d][(o - 2) / REC] = regs[first[d] + (o - 2) / REC];
        if (o >= 1 && o < endo) e_busy = 32'd1;
        if (o == endo) e_done = 32'd1;
        if (o >= 1) e_ra = 32'(first[d] + (o - 1) / REC);
        if (o >= 4 && o < endo) begin
          k = (o - 4) / REC;
          w = (o - 4) % REC;
          if (w < 5 * FRAME) begin
            b  = w / FRAME;
            bi = (w % FRAME) / CD;
            if (b == 0) byt = 8'(first[d] + k);
            else        byt = 8'(snap[d][k] >> (8 * (4 - b)));
            if (bi == 0)      e_tx = 32'd0;
            else if (bi == 9) e_tx = 32'd1;
            else              e_tx = {31'd0, byt[bi-1]};
          end
        end
      end
      chk($sformatf("tx[%0d]", d), 32'(g_tx), e_tx);
      chk($sformatf("busy[%0d]", d), 32'(g_busy), e_busy);
      chk($sformatf("done[%0d]", d), 32'(g_done), e_done);
      chk($sformatf("regAddr[%0d]", d), 32'(g_ra), e_ra);
      if (rst_n && g_st && (!act[d] || o > endo)) begin
        t0[d]  = cyc;
        act[d] = 1'b1;
      end
    end
  end

  // UART decoder feeding byte queues, plus done counters.
  initial forever begin
    @(negedge clk);
    if (done0) dn0++;
    if (done1) dn1++;
    for (int d = 0; d < 2; d++) begin
      logic txv;
      int p;
      txv = (d == 0) ? tx0 : tx1;
      if (!rst_n) begin
        dec_pos[d] = -1;
      end else if (dec_pos[d] < 0) begin
        if (txv == 1'b0) dec_pos[d] = 1;
      end else begin
        p = dec_pos[d];
        if (p % CD == 1 && p / CD >= 1 && p / CD <= 8) dec_sh[d] = {txv, dec_sh[d][7:1]};
        if (p == FRAME - 1) begin
          if (d == 0) rxq0.push_back(dec_sh[d]);
          else        rxq1.push_back(dec_sh[d]);
          dec_pos[d] = -1;
        end else begin
          dec_pos[d] = p + 1;
        end
      end
    end
  end

  initial begin
    #(600000);
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int ts, td, mid, tgt;
    for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 + 32'(i);
    regs[0] = 32'h0000_0010;

    repeat (5) step();
    rst_n = 1'b1;

    // Idle after reset: per-cycle model expects tx=1, busy=0, regAddr=0.
    repeat (1000) step();
    chk("idle_rx_bytes", 32'(rxq0.size() + rxq1.size()), 32'd0);

    // Single register 5.
    rxq1.delete(); dn1 = 0;
    start1 = 1'b1; ts = cyc; step(); start1 = 1'b0;
    td = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done1) begin td = cyc; break; end
    end
    chk("single_done_latency", 32'(td - ts), 32'd204);
    step(); step();
    chk("single_bytes", 32'(rxq1.size()), 32'd5);
    chk_rec("single_rec", 1, 0, 40'h05_A5_00_00_05);

    // Full dump with a snapshot race on reg 3 and a start pulse mid-dump.
    regs[3] = 32'd1;
    rxq0.delete(); dn0 = 0;
    repeat ($urandom_range(0, 7)) step();
    start0 = 1'b1; ts = cyc; step(); start0 = 1'b0;
    while (cyc < ts + 3 + 3 * REC) step();
    regs[3] = 32'd2;
    mid = ts + int'($urandom_range(300, 6000));
    while (cyc < mid) step();
    start0 = 1'b1; step(); start0 = 1'b0;
    while (cyc < ts + 32 * REC + 10) step();
    chk("full_bytes", 32'(rxq0.size()), 32'd160);
    chk("full_dones", 32'(dn0), 32'd1);
    chk_rec("full_rec0", 0, 0, 40'h00_00_00_00_10);
    chk_rec("full_rec31", 0, 155, 40'h1F_A5_00_00_1F);
    chk_rec("snap_rec3", 0, 15, 40'h03_00_00_00_01);
    regs[3] = 32'hA500_0003;

    // Start held high restarts right after each done.
    rxq1.delete(); dn1 = 0;
    start1 = 1'b1; ts = cyc;
    while (cyc < ts + 3 * REC) step();
    start1 = 1'b0;
    while (cyc < ts + 700) step();
    chk("held_dones", 32'(dn1), 32'd3);
    chk("held_bytes", 32'(rxq1.size()), 32'd15);

    // Reset in the middle of a zero data bit.
    rxq0.delete(); dn0 = 0;
    start0 = 1'b1; ts = cyc; step(); start0 = 1'b0;
    tgt = ts + 4 + FRAME + CD * int'($urandom_range(1, 8)) + 1;
    while (cyc < tgt) step();
    chk("pre_rst_tx", 32'(tx0), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_tx", 32'(tx0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_regaddr", 32'(ra0), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    rxq0.delete(); dn0 = 0;
    start0 = 1'b1; ts = cyc; step(); start0 = 1'b0;
    while (cyc < ts + 32 * REC + 10) step();
    chk("post_rst_bytes", 32'(rxq0.size()), 32'd160);
    chk("post_rst_dones", 32'(dn0), 32'd1);
    chk_rec("post_rst_rec0", 0, 0, 40'h00_00_00_00_10);

    // Random traffic: sporadic starts and register updates, checked cycle by cycle.
    for (int i = 0; i < 8000; i++) begin
      start0 = ($urandom_range(0, 299) == 0);
      start1 = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) regs[$urandom_range(0, 31)] = $urandom;
      step();
    end
    start0 = 1'b0; start1 = 1'b0;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
